// File: rtl/block_interleaver_if.sv
// Handshake bundle for the block interleaver: upstream symbol stream,
// downstream symbol stream and status flags.
interface block_interleaver_if #(
    parameter int unsigned W = 1
);
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic         in_sof;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sof;
    logic         out_eof;
    logic [W-1:0] out_data;
    logic         frame_err;
    logic [1:0]   bank_full;

    // Producer/consumer side (testbench or surrounding pipeline)
    modport master (
        output mode, in_valid, in_sof, in_data, out_ready,
        input  in_ready, out_valid, out_sof, out_eof, out_data, frame_err, bank_full
    );

    // Interleaver side
    modport slave (
        input  mode, in_valid, in_sof, in_data, out_ready,
        output in_ready, out_valid, out_sof, out_eof, out_data, frame_err, bank_full
    );
endinterface

// File: rtl/block_interleaver.sv
// Row/column block interleaver/deinterleaver with two ping-pong banks.
// The writer fills one bank linearly while the reader drains the other in
// permuted order; bank_full is the only handoff between the two sides.
module block_interleaver #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4,
    parameter int unsigned W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    block_interleaver_if.slave bus
);
    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned AW = $clog2(N);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [AW-1:0] ROWS_M1   = AW'(ROWS - 1);
    localparam logic [AW-1:0] COLS_M1   = AW'(COLS - 1);
    localparam logic [AW-1:0] ROWS_L    = AW'(ROWS);
    localparam logic [AW-1:0] COLS_L    = AW'(COLS);
    localparam logic [AW-1:0] ONE       = AW'(1);

    typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} wr_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DRAIN = 1'b1} rd_state_e;

    // Storage: bank select in the first dimension
    logic [W-1:0] mem_q [2][N];

    // Writer state
    wr_state_e    wr_state_q, wr_state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic         wbank_q, wbank_d;
    logic [1:0]   bank_mode_q, bank_mode_d;
    logic         frame_err_q, frame_err_d;
    logic         in_ready_c;
    logic         accept_c;
    logic         wr_en_c;
    logic [AW-1:0] wr_addr_c;
    logic         wr_done_c;

    // Shared flags
    logic [1:0]   bank_full_q, bank_full_d;

    // Reader state: inner/outer sub-counters replace k % L and k / L
    rd_state_e    rd_state_q, rd_state_d;
    logic         rbank_q, rbank_d;
    logic [AW-1:0] inner_q, inner_d;
    logic [AW-1:0] outer_q, outer_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic         rd_mode_c;
    logic [AW-1:0] inner_lim_c, outer_lim_c, stride_c;
    logic         rd_load_c;
    logic         rd_last_c;

    // Output register
    logic         out_valid_q, out_valid_d;
    logic         out_sof_q, out_sof_d;
    logic         out_eof_q, out_eof_d;
    logic [W-1:0] out_data_q, out_data_d;

    // Writer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_q  <= W_IDLE;
            wptr_q      <= '0;
            wbank_q     <= 1'b0;
            bank_mode_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            wptr_q      <= wptr_d;
            wbank_q     <= wbank_d;
            bank_mode_q <= bank_mode_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Writer outputs: ready depends only on registered state
    always_comb begin
        in_ready_c = 1'b1;
        if (wr_state_q == W_IDLE) begin
            in_ready_c = ~bank_full_q[wbank_q];
        end
    end

    assign accept_c = bus.in_valid & in_ready_c;

    // Writer next state: sof always restarts at addr 0 of the current bank
    always_comb begin
        wr_state_d  = wr_state_q;
        wptr_d      = wptr_q;
        wbank_d     = wbank_q;
        bank_mode_d = bank_mode_q;
        frame_err_d = 1'b0;
        wr_en_c     = 1'b0;
        wr_addr_c   = wptr_q;
        wr_done_c   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (accept_c && bus.in_sof) begin
                    wr_en_c              = 1'b1;
                    wr_addr_c            = '0;
                    bank_mode_d[wbank_q] = bus.mode;
                    wptr_d               = ONE;
                    wr_state_d           = W_FILL;
                end
            end
            W_FILL: begin
                if (accept_c) begin
                    wr_en_c = 1'b1;
                    if (bus.in_sof) begin
                        frame_err_d          = 1'b1;
                        wr_addr_c            = '0;
                        bank_mode_d[wbank_q] = bus.mode;
                        wptr_d               = ONE;
                    end else if (wptr_q == LAST_ADDR) begin
                        wr_done_c  = 1'b1;
                        wbank_d    = ~wbank_q;
                        wptr_d     = '0;
                        wr_state_d = W_IDLE;
                    end else begin
                        wptr_d = wptr_q + ONE;
                    end
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Symbol storage write port
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wbank_q][wr_addr_c] <= bus.in_data;
        end
    end

    // Per-bank full flags: set by writer, cleared by reader, never the same bank
    always_comb begin
        bank_full_d = bank_full_q;
        if (rd_load_c && rd_last_c) begin
            bank_full_d[rbank_q] = 1'b0;
        end
        if (wr_done_c) begin
            bank_full_d[wbank_q] = 1'b1;
        end
    end

    // Bank flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank_full_q <= '0;
        end else begin
            bank_full_q <= bank_full_d;
        end
    end

    // Reader state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q <= R_IDLE;
            rbank_q    <= 1'b0;
            inner_q    <= '0;
            outer_q    <= '0;
            raddr_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rbank_q    <= rbank_d;
            inner_q    <= inner_d;
            outer_q    <= outer_d;
            raddr_q    <= raddr_d;
        end
    end

    // Reader outputs: walk geometry of the bank's latched mode
    always_comb begin
        rd_mode_c   = bank_mode_q[rbank_q];
        inner_lim_c = rd_mode_c ? COLS_M1 : ROWS_M1;
        outer_lim_c = rd_mode_c ? ROWS_M1 : COLS_M1;
        stride_c    = rd_mode_c ? ROWS_L : COLS_L;
        rd_load_c   = (~out_valid_q | bus.out_ready) & bank_full_q[rbank_q];
        rd_last_c   = (inner_q == inner_lim_c) && (outer_q == outer_lim_c);
    end

    // Reader next state: addr steps by stride, wraps to the next outer index
    always_comb begin
        rd_state_d = rd_state_q;
        rbank_d    = rbank_q;
        inner_d    = inner_q;
        outer_d    = outer_q;
        raddr_d    = raddr_q;
        case (rd_state_q)
            R_IDLE:  if (rd_load_c) rd_state_d = R_DRAIN;
            R_DRAIN: if (rd_load_c && rd_last_c) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
        if (rd_load_c) begin
            if (inner_q == inner_lim_c) begin
                inner_d = '0;
                if (rd_last_c) begin
                    outer_d = '0;
                    raddr_d = '0;
                    rbank_d = ~rbank_q;
                end else begin
                    outer_d = outer_q + ONE;
                    raddr_d = outer_q + ONE;
                end
            end else begin
                inner_d = inner_q + ONE;
                raddr_d = raddr_q + stride_c;
            end
        end
    end

    // Output register next value: hold while stalled
    always_comb begin
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        out_data_d  = out_data_q;
        if (rd_load_c) begin
            out_valid_d = 1'b1;
            out_sof_d   = (rd_state_q == R_IDLE);
            out_eof_d   = rd_last_c;
            out_data_d  = mem_q[rbank_q][raddr_q];
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign bus.out_data  = out_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.bank_full = bank_full_q;

endmodule

// File: tb/tb_block_interleaver.sv
// Bench for block_interleaver on a non-square 3x5 block with 8-bit symbols,
// so that the two modes produce different permutations.
module tb_block_interleaver;
    localparam int unsigned ROWS = 3;
    localparam int unsigned COLS = 5;
    localparam int unsigned W    = 8;
    localparam int          N    = ROWS * COLS;

    typedef struct packed {
        logic [W-1:0] d;
        logic         sof;
        logic         eof;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    block_interleaver_if #(.W(W)) bus ();

    block_interleaver #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    exp_t         expq [$];
    logic [W-1:0] cur [$];
    bit           in_frame  = 1'b0;
    bit           cur_mode  = 1'b0;
    bit           ferr_pend = 1'b0;
    bit           stall_prev = 1'b0;
    logic [W+1:0] prev_o = '0;
    exp_t         e;
    exp_t         ne;

    // Observation
    logic [W-1:0] got_q [$];
    int ferr_cnt  = 0;
    int out_cnt   = 0;
    int t0        = -1;
    int first_ov  = -1;
    int last_out  = -1;
    int ordy_mode = 0;

    logic [W-1:0] lit_il [N] = '{8'd0, 8'd5, 8'd10, 8'd1, 8'd6, 8'd11, 8'd2, 8'd7,
                                 8'd12, 8'd3, 8'd8, 8'd13, 8'd4, 8'd9, 8'd14};

    always @(posedge clk) cyc <= cyc + 1;

    // Output position k reads input index perm(k) of the frame
    function automatic int perm(input bit m, input int k);
        if (!m) return (k % ROWS) * COLS + k / ROWS;
        return (k % COLS) * ROWS + k / COLS;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    // Compare process: all handshakes observed mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            chk("frame_err", 32'(bus.frame_err), 32'(ferr_pend));
            ferr_pend = 1'b0;
            if (bus.frame_err) ferr_cnt++;
            if (stall_prev) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_payload", 32'({bus.out_data, bus.out_sof, bus.out_eof}), 32'(prev_o));
            end
            if (bus.out_valid && first_ov < 0) first_ov = cyc;
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got data %0h, required no output", bus.out_data);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e.d));
                    chk("out_sof", 32'(bus.out_sof), 32'(e.sof));
                    chk("out_eof", 32'(bus.out_eof), 32'(e.eof));
                end
                got_q.push_back(bus.out_data);
                out_cnt++;
                last_out = cyc;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_o     = {bus.out_data, bus.out_sof, bus.out_eof};
            if (bus.in_valid && bus.in_ready) begin
                if (t0 < 0) t0 = cyc + 1;
                if (bus.in_sof) begin
                    if (in_frame) ferr_pend = 1'b1;
                    in_frame = 1'b1;
                    cur.delete();
                    cur_mode = bus.mode;
                    cur.push_back(bus.in_data);
                end else if (in_frame) begin
                    cur.push_back(bus.in_data);
                end
                if (in_frame && cur.size() == N) begin
                    for (int k = 0; k < N; k++) begin
                        ne.d   = cur[perm(cur_mode, k)];
                        ne.sof = (k == 0);
                        ne.eof = (k == N - 1);
                        expq.push_back(ne);
                    end
                    in_frame = 1'b0;
                end
            end
        end
    end

    // Downstream ready: 0 = always, 1 = random, 2 = held low
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ordy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    task automatic drive_beat(input logic [W-1:0] d, input bit sof, input bit m);
        bit acc = 1'b0;
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = sof;
        bus.mode     = m;
        while (!acc && n < 400) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("in_accept_timeout", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input bit m, input logic [W-1:0] base);
        for (int k = 0; k < N; k++) drive_beat(base + W'(k), k == 0, m);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (expq.size() != 0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 32'(expq.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_sof"}, 32'(bus.out_sof), 32'd0);
        chk({tag, "_out_eof"}, 32'(bus.out_eof), 32'd0);
        chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        chk({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
        chk({tag, "_bank_full"}, 32'(bus.bank_full), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] y [$];
        int n;
        bus.mode     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Interleave 0..14, first output latency
        t0 = -1;
        first_ov = -1;
        got_q.delete();
        send_frame(1'b0, 8'd0);
        wait_drain(100);
        chk("first_out_latency", 32'(first_ov), 32'(t0 + N));
        chk("il_count", 32'(got_q.size()), 32'(N));
        if (got_q.size() == N)
            for (int k = 0; k < N; k++) chk("il_literal", 32'(got_q[k]), 32'(lit_il[k]));

        // Deinterleave the interleaved frame: round trip restores 0..14
        y = got_q;
        got_q.delete();
        for (int k = 0; k < N; k++) drive_beat(y[k], k == 0, 1'b1);
        wait_drain(100);
        chk("rt_count", 32'(got_q.size()), 32'(N));
        if (got_q.size() == N)
            for (int k = 0; k < N; k++) chk("rt_restore", 32'(got_q[k]), 32'(k));

        // Two frames back-to-back stream without a bubble
        t0 = -1;
        first_ov = -1;
        out_cnt = 0;
        send_frame(1'b0, 8'h40);
        send_frame(1'b1, 8'h80);
        wait_drain(200);
        chk("b2b_count", 32'(out_cnt), 32'(2 * N));
        chk("b2b_span", 32'(last_out - first_ov + 1), 32'(2 * N));
        chk("b2b_latency", 32'(first_ov), 32'(t0 + N));

        // Backpressure: both banks fill, then release
        ordy_mode = 2;
        @(posedge clk);
        #1;
        out_cnt = 0;
        fork
            begin
                send_frame(1'b0, 8'h10);
                send_frame(1'b1, 8'h30);
                send_frame(1'b0, 8'h50);
            end
            begin
                repeat (40) @(posedge clk);
                #2;
                chk("bp_bank_full", 32'(bus.bank_full), 32'd3);
                chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
                ordy_mode = 0;
            end
        join
        wait_drain(300);
        chk("bp_count", 32'(out_cnt), 32'(3 * N));

        // sof at symbol 7 of a frame: partial frame discarded
        ferr_cnt = 0;
        out_cnt = 0;
        for (int k = 0; k < 7; k++) drive_beat(8'hA0 + 8'(k), k == 0, 1'b0);
        send_frame(1'b1, 8'hC0);
        wait_drain(100);
        chk("ferr_count", 32'(ferr_cnt), 32'd1);
        chk("mid_count", 32'(out_cnt), 32'(N));

        // Asynchronous reset mid-drain
        send_frame(1'b0, 8'h11);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        expq.delete();
        cur.delete();
        in_frame   = 1'b0;
        ferr_pend  = 1'b0;
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_cnt = 0;
        for (int k = 0; k < 4; k++) drive_beat(8'hE0 + 8'(k), 1'b0, 1'b0);
        send_frame(1'b1, 8'h20);
        wait_drain(100);
        chk("post_rst_count", 32'(out_cnt), 32'(N));

        // Random data, alternating modes, random gaps and random out_ready
        ordy_mode = 1;
        out_cnt = 0;
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < N; k++) begin
                drive_beat(W'($urandom), k == 0, 1'(f % 2));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wait_drain(2000);
        chk("rand_count", 32'(out_cnt), 32'(8 * N));
        ordy_mode = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_interleaver.md
Name: block_interleaver

Overview:
- Parametrised row/column block interleaver/deinterleaver with ping-pong banks and valid/ready handshakes on both sides.
- Supersedes the fixed 4x4, 1-bit, free-running deinterleaver. Adds configurable geometry and symbol width, a per-frame mode select, frame sync, and backpressure.
- Sits between the channel encoder and the modulator when run as an interleaver, and between the demodulator and the decoder when run as a deinterleaver.

Parameters:
- ROWS, 4, number of rows in the block (>=2).
- COLS, 4, number of columns in the block (>=2).
- W, 1, symbol width in bits (1 = hard bits, >1 = soft symbols).
- Derived: N = ROWS*COLS symbols per frame; AW = clog2(N).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- mode  in  1  0 = interleave, 1 = deinterleave. Sampled with the in_sof beat.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  block can accept a symbol.
- in_sof  in  1  first symbol of a frame; qualified by in_valid & in_ready.
- in_data  in  W  input symbol.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_sof  out  1  first symbol of output frame.
- out_eof  out  1  last symbol of output frame.
- out_data  out  W  output symbol.
- frame_err  out  1  one-cycle pulse: in_sof seen mid-frame.
- bank_full  out  2  per-bank "holds complete frame" flags.

Behaviour:
- Reset (rst low, asynchronous): all pointers = 0, bank_full = 0, out_valid = 0, out_sof = 0, out_eof = 0, out_data = 0, frame_err = 0, write bank = 0, read bank = 0, writer in IDLE. Memory contents are don't-care. Reset mid-frame discards all data. First accept after reset needs in_sof.
- Storage: two banks of N x W. Writer fills one bank while the reader drains the other.
- Writer FSM:
  - IDLE: in_ready = !bank_full[wbank]. Beats without in_sof are accepted and dropped.
  - Accepted in_sof beat: latch mode into bank_mode[wbank], write addr 0, go to FILL with wptr = 1.
  - FILL: in_ready = 1. Each accepted beat writes linear addr wptr and increments it.
  - On the beat with wptr = N-1: set bank_full[wbank], toggle wbank, go to IDLE.
- in_sof during FILL:
  - Pulse frame_err for one cycle.
  - Discard the partial frame and restart at addr 0 of the same bank; wptr becomes 1.
  - Re-latch mode from this beat.
- Reader FSM (IDLE/DRAIN), counter k = 0..N-1:
  - Read address if bank_mode = 0: (k % ROWS)*COLS + k/ROWS.
  - Read address if bank_mode = 1: (k % COLS)*ROWS + k/COLS.
  - Implement with row/col sub-counters, not divide/modulo hardware.
- Output register:
  - Loads when !out_valid | out_ready and bank_full[rbank] = 1.
  - out_sof = (k = 0); out_eof = (k = N-1).
  - While out_valid & !out_ready, out_data, out_sof and out_eof hold stable.
- When the k = N-1 symbol loads: clear bank_full[rbank] on that edge, toggle rbank, reset k to 0. That bank may be written starting the next cycle.
- Latency: first input beat accepted at edge t0, continuous input, out_ready = 1.
  - Frame becomes full at edge t0+N-1.
  - First output beat is registered at edge t0+N.
  - Steady-state throughput is 1 symbol/clk with no bubbles between frames.
- Simultaneous events:
  - Writer completing bank A while reader finishes bank B on the same edge: both flags update independently.
  - Writer completing bank A while reader wants to start A: the reader starts on the next edge (bank_full is the only handoff).
- Backpressure: with both banks full, in_ready = 0 until the reader releases a bank. No symbol is ever lost or overwritten.
- mode applies per frame. Frames of different modes may alternate back-to-back.

Test Plan:
- ROWS=COLS=4, W=1, mode=0, input symbols 0..15 (W=8 bench variant) -> output order 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15. out_sof on the first symbol, out_eof on the last, first out_valid at edge t0+16.
- ROWS=3, COLS=5, W=4: interleave frame 0..14, feed the output back with mode=1 -> restores 0..14. Two consecutive frames stream with no idle cycle.
- out_ready held low for 40 cycles with continuous input -> two frames buffered, bank_full = 2'b11, in_ready = 0. After release, output is the exact two frames in order with no drops.
- in_sof reasserted at symbol 7 of a 16-symbol frame -> frame_err pulses once, the partial frame never appears at the output, and the new frame is output correctly.
- rst pulsed low mid-DRAIN with out_valid = 1 -> all outputs 0 immediately (asynchronous). Post-reset beats without in_sof are dropped, and the next in_sof frame is correct.
- Alternating mode 0/1 frames back-to-back with random out_ready -> each frame is permuted per its own latched mode, checked against the reference model.
